// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: multi-cycle control FSM for the RV32I core.
// Steps FETCH -> DECODE -> EXECUTE -> (MEM) -> WRITEBACK around the decoder,
// ALU, register file and PC register. It turns the decoder's static controls
// into per-cycle write strobes and bus requests. It also provides debug
// halt/resume, bus-timeout and illegal-opcode traps, and a retire counter.
//
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   opcode_i             decoder opcode
//   branch_i             decoder branch flag (JAL/JALR/BRANCH)
//   reg_write_i          decoder register-write enable
//   mem_write_i          decoder store flag
//   branch_taken_i       branch compare result, valid in EXECUTE
//   imem_ack_i           instruction memory ack
//   dmem_ack_i           data memory ack
//   halt_req_i           debug halt request (honoured in a retire cycle)
//   resume_i             debug resume
//   imem_req_o, ir_we_o  fetch request, instruction register load
//   dmem_req_o, dmem_we_o data request, data write enable
//   rf_we_o, pc_we_o     register file write, PC update (retire)
//   pc_sel_o             0 = PC+4, 1 = branch/jump target
//   halted_o             halted by debug
//   illegal_o, bus_err_o sticky trap causes
//   state_o              current state encoding
//   instret_o            retired-instruction count
module multicycle_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned INSTRET_WIDTH  = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [6:0]               opcode_i,
    input  logic                     branch_i,
    input  logic                     reg_write_i,
    input  logic                     mem_write_i,
    input  logic                     branch_taken_i,
    input  logic                     imem_ack_i,
    input  logic                     dmem_ack_i,
    input  logic                     halt_req_i,
    input  logic                     resume_i,
    output logic                     imem_req_o,
    output logic                     ir_we_o,
    output logic                     dmem_req_o,
    output logic                     dmem_we_o,
    output logic                     rf_we_o,
    output logic                     pc_we_o,
    output logic                     pc_sel_o,
    output logic                     halted_o,
    output logic                     illegal_o,
    output logic                     bus_err_o,
    output logic [2:0]               state_o,
    output logic [INSTRET_WIDTH-1:0] instret_o
);

    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // Expiry fires in the cycle whose count is one below the limit, so the
    // request is seen for exactly TIMEOUT_CYCLES cycles before the trap.
    localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? TO_W'(TIMEOUT_CYCLES - 1) : '0;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALTED    = 3'd5,
        S_TRAP      = 3'd6
    } state_t;

    state_t                   r_state;
    logic                     r_taken;
    logic [TO_W-1:0]          r_cnt;
    logic [INSTRET_WIDTH-1:0] r_instret;
    logic                     r_illegal;
    logic                     r_bus_err;

    state_t w_next;
    logic   w_imem_req;
    logic   w_ir_we;
    logic   w_dmem_req;
    logic   w_dmem_we;
    logic   w_rf_we;
    logic   w_pc_we;
    logic   w_pc_sel;
    logic   w_halted;
    logic   w_retire;
    logic   w_set_illegal;
    logic   w_set_bus_err;
    logic   w_expire;
    logic   w_wait;

    assign w_expire = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST);

    // Cycles spent waiting on an ack in a bus state
    assign w_wait = ((r_state == S_FETCH) && !imem_ack_i) ||
                    ((r_state == S_MEM)   && !dmem_ack_i);

    // Next-state and strobe decode
    always_comb begin
        w_next        = r_state;
        w_imem_req    = 1'b0;
        w_ir_we       = 1'b0;
        w_dmem_req    = 1'b0;
        w_dmem_we     = 1'b0;
        w_rf_we       = 1'b0;
        w_pc_we       = 1'b0;
        w_pc_sel      = 1'b0;
        w_halted      = 1'b0;
        w_retire      = 1'b0;
        w_set_illegal = 1'b0;
        w_set_bus_err = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_imem_req = 1'b1;
                if (imem_ack_i) begin
                    w_ir_we = 1'b1;
                    w_next  = S_DECODE;
                end else if (w_expire) begin
                    w_next        = S_TRAP;
                    w_set_bus_err = 1'b1;
                end
            end
            S_DECODE: begin
                w_next = S_EXECUTE;
            end
            S_EXECUTE: begin
                case (opcode_i)
                    OP_LOAD, OP_STORE: w_next = S_MEM;
                    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
                    OP_ALU, OP_ALUI, OP_FENCE, OP_SYSTEM: w_next = S_WRITEBACK;
                    default: begin
                        w_next        = S_TRAP;
                        w_set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                w_dmem_req = 1'b1;
                w_dmem_we  = mem_write_i;
                if (dmem_ack_i) begin
                    // Stores have nothing to write back and retire here
                    if (opcode_i == OP_STORE) begin
                        w_pc_we  = 1'b1;
                        w_retire = 1'b1;
                    end else begin
                        w_next = S_WRITEBACK;
                    end
                end else if (w_expire) begin
                    w_next        = S_TRAP;
                    w_set_bus_err = 1'b1;
                end
            end
            S_WRITEBACK: begin
                w_rf_we  = reg_write_i;
                w_pc_we  = 1'b1;
                w_pc_sel = branch_i && ((opcode_i == OP_JAL) || (opcode_i == OP_JALR) || r_taken);
                w_retire = 1'b1;
            end
            S_HALTED: begin
                w_halted = 1'b1;
                if (resume_i) begin
                    w_next = S_FETCH;
                end
            end
            S_TRAP: begin
                w_next = S_TRAP;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase

        if (w_retire) begin
            w_next = halt_req_i ? S_HALTED : S_FETCH;
        end
    end

    // State, timeout counter, retire counter and sticky trap flags
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state   <= S_FETCH;
            r_taken   <= 1'b0;
            r_cnt     <= '0;
            r_instret <= '0;
            r_illegal <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_EXECUTE) begin
                r_taken <= branch_taken_i;
            end
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (w_wait && (TIMEOUT_CYCLES != 0)) begin
                r_cnt <= r_cnt + TO_W'(1);
            end
            if (w_retire) begin
                r_instret <= r_instret + INSTRET_WIDTH'(1);
            end
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
            if (w_set_bus_err) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    // Every output is held at zero while reset is low
    assign imem_req_o = rst_ni & w_imem_req;
    assign ir_we_o    = rst_ni & w_ir_we;
    assign dmem_req_o = rst_ni & w_dmem_req;
    assign dmem_we_o  = rst_ni & w_dmem_we;
    assign rf_we_o    = rst_ni & w_rf_we;
    assign pc_we_o    = rst_ni & w_pc_we;
    assign pc_sel_o   = rst_ni & w_pc_sel;
    assign halted_o   = rst_ni & w_halted;
    assign illegal_o  = rst_ni & r_illegal;
    assign bus_err_o  = rst_ni & r_bus_err;
    assign state_o    = rst_ni ? r_state : 3'd0;
    assign instret_o  = rst_ni ? r_instret : '0;

endmodule
